alu_op_sequencer: RTL and testbench

Command-side master for the team's combinational 8-bit ALU.
- Accepts operation commands over a valid/ready handshake and reads operands from a small local register file.
- Drives the ALU opcode and operand inputs, then captures y, zero and overflow.
- Writes the result back to the register file and returns a response over a second valid/ready handshake.
- Sits between the control/test harness and the ALU instance.

---
 rtl/alu_op_sequencer_if.sv | 47 ++++
 rtl/alu_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU and response bundle for alu_op_sequencer.
// master = sequencer side, slave = harness/ALU side.
interface alu_op_sequencer_if #(
    parameter int RIDX_W = 2
);
    // Both handshakes: a transfer occurs on a rising edge where valid && ready;
    // the producer holds valid and payload stable until that edge.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [RIDX_W-1:0] cmd_ra;
    logic [RIDX_W-1:0] cmd_rb;
    logic [RIDX_W-1:0] cmd_rd;
    logic [7:0]        cmd_imm;

    logic [3:0]        alu_opcode;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [7:0]        alu_y;
    logic              alu_zero;
    logic              alu_overflow;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_data;
    logic              rsp_zero;
    logic              rsp_overflow;
    logic              rsp_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm,
        input  alu_y, alu_zero, alu_overflow,
        input  rsp_ready,
        output cmd_ready,
        output alu_opcode, alu_a, alu_b,
        output rsp_valid, rsp_data, rsp_zero, rsp_overflow, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm,
        output alu_y, alu_zero, alu_overflow,
        output rsp_ready,
        input  cmd_ready,
        input  alu_opcode, alu_a, alu_b,
        input  rsp_valid, rsp_data, rsp_zero, rsp_overflow, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 8-bit combinational ALU with a local register file.
// Optional macro LOCAL_ZERO_EN: derive rsp_zero from alu_y instead of alu_zero.
module alu_op_sequencer #(
    parameter int NREGS  = 4,
    parameter int RIDX_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_op_sequencer_if.master    bus,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_DIV      = 4'h3;
    localparam logic [3:0] OP_LAST_ALU = 4'h9;
    localparam logic [3:0] OP_LOADI    = 4'hF;

    state_t            r_state;
    state_t            w_next;

    logic [7:0]        r_regs [NREGS];
    logic [3:0]        r_op;
    logic [RIDX_W-1:0] r_rd;
    logic [7:0]        r_imm;
    logic [3:0]        r_alu_opcode;
    logic [7:0]        r_alu_a;
    logic [7:0]        r_alu_b;
    logic [7:0]        r_rsp_data;
    logic              r_rsp_zero;
    logic              r_rsp_overflow;
    logic              r_rsp_err;

    logic              w_cmd_ready;
    logic              w_rsp_valid;
    logic              w_accept;
    logic              w_exec;
    logic              w_is_alu;
    logic              w_err;
    logic              w_y_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_accept    = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_EXEC;
                end
            end
            S_EXEC: begin
                w_exec = 1'b1;
                w_next = S_RESP;
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_is_alu = (r_op <= OP_LAST_ALU);
    // Divide-by-zero is judged on the latched operand, which is what the ALU sees.
    assign w_err    = ((r_op == OP_DIV) && (r_alu_b == 8'h00)) ||
                      (!w_is_alu && (r_op != OP_LOADI));

`ifdef LOCAL_ZERO_EN
    assign w_y_zero = (bus.alu_y == 8'h00);
`else
    assign w_y_zero = bus.alu_zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_op           <= 4'h0;
            r_rd           <= '0;
            r_imm          <= 8'h00;
            r_alu_opcode   <= 4'h0;
            r_alu_a        <= 8'h00;
            r_alu_b        <= 8'h00;
            r_rsp_data     <= 8'h00;
            r_rsp_zero     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op         <= bus.cmd_op;
                r_rd         <= bus.cmd_rd;
                r_imm        <= bus.cmd_imm;
                r_alu_opcode <= (bus.cmd_op == OP_LOADI) ? 4'h0 : bus.cmd_op;
                r_alu_a      <= r_regs[bus.cmd_ra];
                r_alu_b      <= r_regs[bus.cmd_rb];
            end
            if (w_exec) begin
                if (w_err) begin
                    r_rsp_data     <= 8'h00;
                    r_rsp_zero     <= 1'b0;
                    r_rsp_overflow <= 1'b0;
                    r_rsp_err      <= 1'b1;
                end else if (r_op == OP_LOADI) begin
                    r_regs[r_rd]   <= r_imm;
                    r_rsp_data     <= r_imm;
                    r_rsp_zero     <= (r_imm == 8'h00);
                    r_rsp_overflow <= 1'b0;
                    r_rsp_err      <= 1'b0;
                end else begin
                    r_regs[r_rd]   <= bus.alu_y;
                    r_rsp_data     <= bus.alu_y;
                    r_rsp_zero     <= w_y_zero;
                    r_rsp_overflow <= bus.alu_overflow;
                    r_rsp_err      <= 1'b0;
                end
            end
        end
    end

    assign bus.cmd_ready    = w_cmd_ready;
    assign bus.rsp_valid    = w_rsp_valid;
    assign bus.alu_opcode   = r_alu_opcode;
    assign bus.alu_a        = r_alu_a;
    assign bus.alu_b        = r_alu_b;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_zero     = r_rsp_zero;
    assign bus.rsp_overflow = r_rsp_overflow;
    assign bus.rsp_err      = r_rsp_err;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU stub, register-file reference
// model and an expected-response queue; randomized commands plus directed cases.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic       zero_fault;
  logic [8:0] alu_r;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  m_regs [4];
  logic [10:0] exp_q [$];

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.RIDX_W(2)) bus ();

  alu_op_sequencer #(.NREGS(4), .RIDX_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Team ALU behaviour: {overflow, y}
  function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    logic [7:0]  y;
    logic        ov;
    y = 8'h00;
    ov = 1'b0;
    p = 16'h0000;
    case (op)
      4'h0: begin y = a + b; ov = (a[7] == b[7]) && (y[7] != a[7]); end
      4'h1: begin y = a - b; ov = (a[7] != b[7]) && (y[7] != a[7]); end
      4'h2: begin p = a * b; y = p[7:0]; ov = (p[15:8] != 8'h00); end
      4'h3: begin y = (b == 8'h00) ? 8'h00 : a / b; end
      4'h4: y = a & b;
      4'h5: y = a | b;
      4'h6: y = a ^ b;
      4'h7: y = ~a;
      4'h8: begin y = {a[6:0], 1'b0}; ov = a[7]; end
      4'h9: y = {1'b0, a[7:1]};
      default: y = 8'h00;
    endcase
    return {ov, y};
  endfunction

  assign alu_r            = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b);
  assign bus.alu_y        = alu_r[7:0];
  assign bus.alu_overflow = alu_r[8];
  assign bus.alu_zero     = (alu_r[7:0] == 8'h00) ^ zero_fault;

  // Reference model: expected response {err, ov, zero, data} and ALU view {opcode, a, b}.
  task automatic model_exec(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                            input logic [1:0] rd, input logic [7:0] imm,
                            output logic [10:0] exp_rsp, output logic [19:0] exp_alu);
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] r;
    a = m_regs[ra];
    b = m_regs[rb];
    exp_alu = {(op == 4'hF) ? 4'h0 : op, a, b};
    if (op == 4'hF) begin
      m_regs[rd] = imm;
      exp_rsp = {1'b0, 1'b0, imm == 8'h00, imm};
    end else if (op > 4'h9 || (op == 4'h3 && b == 8'h00)) begin
      exp_rsp = {1'b1, 1'b0, 1'b0, 8'h00};
    end else begin
      r = alu_ref(op, a, b);
      m_regs[rd] = r[7:0];
      exp_rsp = {1'b0, r[8], r[7:0] == 8'h00, r[7:0]};
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
  endtask

  task automatic drive_idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'h0;
    bus.cmd_ra    = 2'd0;
    bus.cmd_rb    = 2'd0;
    bus.cmd_rd    = 2'd0;
    bus.cmd_imm   = 8'h00;
    bus.rsp_ready = 1'b0;
  endtask

  // Full transaction; lat = edges from accept edge until rsp_valid seen (-1 on timeout).
  task automatic run_cmd(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] rd, input logic [7:0] imm, input int stall,
                         output logic [10:0] got_rsp, output logic [19:0] got_alu, output int lat);
    int n;
    bus.cmd_op    = op;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_rd    = rd;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'($urandom);
    bus.cmd_ra    = 2'($urandom);
    bus.cmd_rb    = 2'($urandom);
    bus.cmd_rd    = 2'($urandom);
    bus.cmd_imm   = 8'($urandom);
    got_alu = {bus.alu_opcode, bus.alu_a, bus.alu_b};
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.rsp_valid) lat = -1;
    got_rsp = {bus.rsp_err, bus.rsp_overflow, bus.rsp_zero, bus.rsp_data};
    repeat (stall) begin
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    zero_fault = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid);
    end
    n_checks++;
    if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== 20'h0) begin
      n_errors++; $display("FAIL reset_alu got=%h exp=0", {bus.alu_opcode, bus.alu_a, bus.alu_b});
    end
    n_checks++;
    if ({bus.rsp_err, bus.rsp_overflow, bus.rsp_zero, bus.rsp_data} !== 11'h0) begin
      n_errors++; $display("FAIL reset_rsp got=%h exp=0", {bus.rsp_err, bus.rsp_overflow, bus.rsp_zero, bus.rsp_data});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
  endtask

  task automatic test_loadi();
    logic [10:0] e_rsp; logic [19:0] e_alu; logic [10:0] g_rsp; logic [19:0] g_alu; int lat;
    logic [7:0] vals [2];
    vals[0] = 8'h7F;
    vals[1] = 8'h01;
    for (int i = 0; i < 2; i++) begin
      model_exec(4'hF, 2'd0, 2'd0, 2'(i), vals[i], e_rsp, e_alu);
      run_cmd(4'hF, 2'd0, 2'd0, 2'(i), vals[i], 0, g_rsp, g_alu, lat);
      n_checks++;
      if (g_rsp !== e_rsp) begin
        n_errors++; $display("FAIL loadi_rsp r%0d got=%h exp=%h", i, g_rsp, e_rsp);
      end
      n_checks++;
      if (lat !== 2) begin
        n_errors++; $display("FAIL loadi_latency got=%0d exp=2", lat);
      end
      n_checks++;
      if (g_alu[19:16] !== 4'h0) begin
        n_errors++; $display("FAIL loadi_alu_opcode got=%h exp=0", g_alu[19:16]);
      end
    end
  endtask

  task automatic test_add_overflow();
    logic [10:0] e_rsp; logic [19:0] e_alu; logic [10:0] g_rsp; logic [19:0] g_alu; int lat;
    model_exec(4'h0, 2'd0, 2'd1, 2'd2, 8'h00, e_rsp, e_alu);
    run_cmd(4'h0, 2'd0, 2'd1, 2'd2, 8'h00, 0, g_rsp, g_alu, lat);
    n_checks++;
    if (g_rsp !== {1'b0, 1'b1, 1'b0, 8'h80}) begin
      n_errors++; $display("FAIL add_ovf_rsp got=%h exp=%h", g_rsp, {1'b0, 1'b1, 1'b0, 8'h80});
    end
    n_checks++;
    if (g_alu !== e_alu) begin
      n_errors++; $display("FAIL add_ovf_alu got=%h exp=%h", g_alu, e_alu);
    end
    n_checks++;
    if (g_rsp !== e_rsp) begin
      n_errors++; $display("FAIL add_ovf_model got=%h exp=%h", g_rsp, e_rsp);
    end
  endtask

  task automatic test_sub_zero();
    logic [10:0] e_rsp; logic [19:0] e_alu; logic [10:0] g_rsp; logic [19:0] g_alu; int lat;
    model_exec(4'hF, 2'd0, 2'd0, 2'd3, 8'h05, e_rsp, e_alu);
    run_cmd(4'hF, 2'd0, 2'd0, 2'd3, 8'h05, 0, g_rsp, g_alu, lat);
    n_checks++;
    if (g_rsp !== e_rsp) begin
      n_errors++; $display("FAIL loadi_r3 got=%h exp=%h", g_rsp, e_rsp);
    end
`ifdef LOCAL_ZERO_EN
    zero_fault = 1'b1;
`endif
    model_exec(4'h1, 2'd3, 2'd3, 2'd3, 8'h00, e_rsp, e_alu);
    run_cmd(4'h1, 2'd3, 2'd3, 2'd3, 8'h00, 0, g_rsp, g_alu, lat);
    zero_fault = 1'b0;
    n_checks++;
    if (g_rsp !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
      n_errors++; $display("FAIL sub_zero_rsp got=%h exp=%h", g_rsp, {1'b0, 1'b0, 1'b1, 8'h00});
    end
    n_checks++;
    if (g_alu !== e_alu) begin
      n_errors++; $display("FAIL sub_zero_alu got=%h exp=%h", g_alu, e_alu);
    end
  endtask

  task automatic test_div_zero();
    logic [10:0] e_rsp; logic [19:0] e_alu; logic [10:0] g_rsp; logic [19:0] g_alu; int lat;
    model_exec(4'h3, 2'd0, 2'd3, 2'd2, 8'h00, e_rsp, e_alu);
    run_cmd(4'h3, 2'd0, 2'd3, 2'd2, 8'h00, 0, g_rsp, g_alu, lat);
    n_checks++;
    if (g_rsp !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_errors++; $display("FAIL div0_rsp got=%h exp=%h", g_rsp, {1'b1, 1'b0, 1'b0, 8'h00});
    end
    model_exec(4'h5, 2'd2, 2'd2, 2'd2, 8'h00, e_rsp, e_alu);
    run_cmd(4'h5, 2'd2, 2'd2, 2'd2, 8'h00, 0, g_rsp, g_alu, lat);
    n_checks++;
    if (g_alu[15:8] !== 8'h80) begin
      n_errors++; $display("FAIL div0_r2_kept got=%h exp=80", g_alu[15:8]);
    end
    n_checks++;
    if (g_rsp !== e_rsp) begin
      n_errors++; $display("FAIL div0_or_rsp got=%h exp=%h", g_rsp, e_rsp);
    end
  endtask

  task automatic test_unsupported();
    logic [10:0] e_rsp; logic [19:0] e_alu; logic [10:0] g_rsp; logic [19:0] g_alu; int lat;
    logic [1:0] ra, rb, rd;
    for (int op = 10; op <= 14; op++) begin
      ra = 2'($urandom); rb = 2'($urandom); rd = 2'($urandom);
      model_exec(4'(op), ra, rb, rd, 8'h00, e_rsp, e_alu);
      run_cmd(4'(op), ra, rb, rd, 8'($urandom), 0, g_rsp, g_alu, lat);
      n_checks++;
      if (g_rsp !== e_rsp) begin
        n_errors++; $display("FAIL unsupported_op%0d got=%h exp=%h", op, g_rsp, e_rsp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] e_rsp; logic [19:0] e_alu; logic [10:0] g_rsp; int n;
    model_exec(4'h0, 2'd0, 2'd1, 2'd0, 8'h00, e_rsp, e_alu);
    bus.cmd_op = 4'h0; bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd1; bus.cmd_rd = 2'd0;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
    n_checks++;
    g_rsp = {bus.rsp_err, bus.rsp_overflow, bus.rsp_zero, bus.rsp_data};
    if (!bus.rsp_valid || g_rsp !== e_rsp) begin
      n_errors++; $display("FAIL bp_first valid=%b got=%h exp=%h", bus.rsp_valid, g_rsp, e_rsp);
    end
    for (int c = 0; c < 5; c++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op = 4'($urandom); bus.cmd_ra = 2'($urandom);
      bus.cmd_rb = 2'($urandom); bus.cmd_rd = 2'($urandom); bus.cmd_imm = 8'($urandom);
      @(posedge clk); #1;
      g_rsp = {bus.rsp_err, bus.rsp_overflow, bus.rsp_zero, bus.rsp_data};
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || g_rsp !== e_rsp || bus.cmd_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold cyc=%0d valid=%b ready=%b got=%h exp valid=1 ready=0 rsp=%h",
                 c, bus.rsp_valid, bus.cmd_ready, g_rsp, e_rsp);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL bp_release valid=%b ready=%b exp valid=0 ready=1", bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] e_rsp; logic [19:0] e_alu; logic [10:0] g_rsp; logic [19:0] g_alu; int lat; int n;
    logic seen_valid;
    model_exec(4'hF, 2'd0, 2'd0, 2'd1, 8'h33, e_rsp, e_alu);
    run_cmd(4'hF, 2'd0, 2'd0, 2'd1, 8'h33, 0, g_rsp, g_alu, lat);
    n_checks++;
    if (g_rsp !== e_rsp) begin
      n_errors++; $display("FAIL rstmid_loadi got=%h exp=%h", g_rsp, e_rsp);
    end
    bus.cmd_op = 4'h0; bus.cmd_ra = 2'd1; bus.cmd_rb = 2'd1; bus.cmd_rd = 2'd1;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    seen_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.rsp_valid !== 1'b0) seen_valid = 1'b1;
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_rsp_valid_pulsed got=1 exp=0");
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_cmd_ready got=%b exp=1", bus.cmd_ready);
    end
    model_exec(4'h0, 2'd1, 2'd1, 2'd2, 8'h00, e_rsp, e_alu);
    run_cmd(4'h0, 2'd1, 2'd1, 2'd2, 8'h00, 0, g_rsp, g_alu, lat);
    n_checks++;
    if (g_alu[15:8] !== 8'h00) begin
      n_errors++; $display("FAIL rstmid_r1_cleared got=%h exp=00", g_alu[15:8]);
    end
    n_checks++;
    if (g_rsp !== e_rsp) begin
      n_errors++; $display("FAIL rstmid_rsp got=%h exp=%h", g_rsp, e_rsp);
    end
  endtask

  task automatic test_random();
    logic [10:0] e_rsp; logic [19:0] e_alu; logic [10:0] g_rsp; logic [19:0] g_alu; int lat;
    logic [10:0] exp_head;
    logic [3:0] op; logic [1:0] ra, rb, rd; logic [7:0] imm;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: op = 4'hF;
        1: op = 4'($urandom_range(10, 14));
        default: op = 4'($urandom_range(0, 9));
      endcase
      ra = 2'($urandom); rb = 2'($urandom); rd = 2'($urandom); imm = 8'($urandom);
      if ($urandom_range(0, 7) == 0) imm = 8'h00;
      model_exec(op, ra, rb, rd, imm, e_rsp, e_alu);
      exp_q.push_back(e_rsp);
      run_cmd(op, ra, rb, rd, imm, $urandom_range(0, 3), g_rsp, g_alu, lat);
      exp_head = exp_q.pop_front();
      n_checks++;
      if (g_rsp !== exp_head) begin
        n_errors++; $display("FAIL rand_rsp i=%0d op=%h got=%h exp=%h", i, op, g_rsp, exp_head);
      end
      n_checks++;
      if (g_alu !== e_alu) begin
        n_errors++; $display("FAIL rand_alu i=%0d op=%h got=%h exp=%h", i, op, g_alu, e_alu);
      end
      n_checks++;
      if (lat !== 2) begin
        n_errors++; $display("FAIL rand_latency i=%0d got=%0d exp=2", i, lat);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loadi();
    test_add_overflow();
    test_sub_zero();
    test_div_zero();
    test_unsupported();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
